fifo_read: RTL

- Sys_clk-domain reader/checker that drains a byte FIFO filled by the test-pattern writer.
- On an fs/fd job handshake it reads data_len bytes and compares each against the writer's pattern.
- Reports a sticky mismatch/timeout error and the received-byte count.
- Closes the loopback path: key -> pattern write -> FIFO -> fifo_read.

---
 rtl/fifo_read.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_read.sv
// fifo_read: sys_clk-domain reader/checker for the test-pattern loopback.
// On an fs/fd job handshake it drains data_len bytes from a standard-mode FIFO,
// compares each byte against the writer's pattern (byte 0 = part, byte k = k mod 256),
// and reports a sticky error plus the received-byte count.
// Optional feature: define FIFO_READ_ERRCNT_EN to enable the per-job mismatch counter
// on err_cnt; without it err_cnt is tied to zero.
//
// state | meaning
// IDLE  | waiting for fs; outputs from the last job held
// READ  | issuing FIFO reads and comparing returned bytes
// LAST  | job finished (done or timed out); fd high until fs drops
module fifo_read #(
    parameter int          LEN_WIDTH = 16,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fs,
    output logic                 fd,
    output logic                 err,
    input  logic [LEN_WIDTH-1:0] data_len,
    input  logic [7:0]           part,
    output logic                 fifo_rxen,
    input  logic [7:0]           fifo_rxd,
    input  logic                 fifo_empty,
    output logic [LEN_WIDTH-1:0] rx_cnt,
    output logic [15:0]          err_cnt
);

    typedef enum logic [1:0] {IDLE, READ, LAST} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] rd_cnt_q;
    logic [LEN_WIDTH-1:0] rx_cnt_q;
    logic [15:0]          tmo_cnt_q;
    logic                 rd_vld_q;
    logic                 err_q;

    logic                 start;
    logic                 more_to_read;
    logic                 starved;
    logic                 tmo_hit;
    logic                 mismatch;
    logic                 last_cmp;
    logic [7:0]           exp_byte;

    assign start        = (state_q == IDLE) && fs;
    assign more_to_read = rd_cnt_q < len_q;
    // Reads are gated by fs so an abort stops requests in the same cycle.
    assign fifo_rxen    = (state_q == READ) && fs && more_to_read && !fifo_empty;
    assign starved      = (state_q == READ) && fs && more_to_read && fifo_empty;
    assign tmo_hit      = starved && (tmo_cnt_q == TIMEOUT - 16'd1);
    assign exp_byte     = (rx_cnt_q == '0) ? part : rx_cnt_q[7:0];
    assign mismatch     = rd_vld_q && (fifo_rxd != exp_byte);
    assign last_cmp     = rd_vld_q && (rx_cnt_q == len_q - LEN_ONE);

    assign fd     = (state_q == LAST);
    assign err    = err_q;
    assign rx_cnt = rx_cnt_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; an fs drop in READ wins over completion or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fs) state_d = (data_len == '0) ? LAST : READ;
            READ: begin
                if (!fs)          state_d = IDLE;
                else if (last_cmp) state_d = LAST;
                else if (tmo_hit)  state_d = LAST;
            end
            LAST: if (!fs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read/compare datapath: request counter, return pipeline, timeout, sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q     <= '0;
            rd_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            tmo_cnt_q <= '0;
            rd_vld_q  <= 1'b0;
            err_q     <= 1'b0;
        end else if (start) begin
            len_q     <= data_len;
            rd_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            tmo_cnt_q <= '0;
            rd_vld_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rd_vld_q <= fifo_rxen;
            if (fifo_rxen) begin
                rd_cnt_q  <= rd_cnt_q + LEN_ONE;
                tmo_cnt_q <= '0;
            end else if (starved) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
            if (rd_vld_q) rx_cnt_q <= rx_cnt_q + LEN_ONE;
            if (mismatch || tmo_hit) err_q <= 1'b1;
        end
    end

`ifdef FIFO_READ_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Per-job saturating mismatch counter; timeouts are not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                    err_cnt_q <= 16'h0000;
        else if (start)                              err_cnt_q <= 16'h0000;
        else if (mismatch && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule
